onehot_stretch_decoder: RTL

- Registered 3-to-8 decoder that turns encoded events (3-bit code plus valid strobe) into one-hot LED lines, the reverse of the switch-side 8-to-3 priority encoder.
- Each decoded pulse is stretched for a programmable number of cycles so it stays visible on the LEDs.
- Also keeps a saturating event count and, optionally, a sticky record of every code seen.
- Sits between the encoder/event source and the `led` bus in `top`.

---
 rtl/onehot_decoder_pkg.sv | 20 ++
 rtl/onehot_stretch_decoder_hold_timer.sv | 29 ++
 rtl/onehot_stretch_decoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/onehot_decoder_pkg.sv
// Shared types and helpers for the one-hot stretch decoder: FSM states,
// code/LED widths and the 3-to-8 decode used by the datapath.
package onehot_decoder_pkg;

    localparam int CODE_W = 3;
    localparam int LED_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [LED_W-1:0] decode3to8(input logic [CODE_W-1:0] c);
        logic [LED_W-1:0] d;
        d    = '0;
        d[c] = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/onehot_stretch_decoder_hold_timer.sv
// Loadable down-counter that times how long a decoded pulse stays on the LEDs.
// zero flags the last held cycle; dec is ignored once the count reaches zero.
module hold_timer #(
    parameter int  HOLD_CYCLES = 4,
    localparam int W           = $clog2(HOLD_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_stretch_decoder.sv
// Registered 3-to-8 decoder with pulse stretching, saturating event count and
// an optional sticky record of seen codes (built when ONEHOT_STICKY_EN is defined).
module onehot_stretch_decoder
    import onehot_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] code,
    input  logic              valid,
    input  logic              clear,
    output logic [LED_W-1:0]  onehot,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic [LED_W-1:0]  sticky,
    output state_e            fsm_state
);

    localparam int               TW      = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0]    RELOAD  = TW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state;
    logic [LED_W-1:0] decoded;
    logic             timer_zero;

    // valid is an unconditional strobe: there is no ready, every cycle with
    // valid high is one accepted event and retriggers the hold.
    assign decoded   = decode3to8(code);
    assign fsm_state = state;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (valid),
        .load_val (RELOAD),
        .dec      ((state == HOLD) && !valid),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            onehot <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        onehot <= decoded;
                        busy   <= 1'b1;
                        state  <= HOLD;
                    end else begin
                        onehot <= '0;
                    end
                end
                HOLD: begin
                    // A retrigger replaces the held bit in the same edge.
                    if (valid) begin
                        onehot <= decoded;
                    end else if (timer_zero) begin
                        onehot <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    onehot <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // Clear takes effect before a same-cycle event, so clear+valid yields 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (valid) begin
            if (clear) begin
                count <= CNT_W'(1);
            end else if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end
        end else if (clear) begin
            count <= '0;
        end
    end

`ifdef ONEHOT_STICKY_EN
    logic [LED_W-1:0] sticky_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
        end else if (clear) begin
            sticky_q <= valid ? decoded : '0;
        end else if (valid) begin
            sticky_q <= sticky_q | decoded;
        end
    end

    assign sticky = sticky_q;
`else
    assign sticky = '0;
`endif

endmodule
